// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for a weight-stationary systolic array: loads weights, streams
// N input vectors from the input buffer and collects N results into the output buffer.
module systolic_seq_ctrl #(
  parameter int CNT_BW    = 8,
  parameter int WLOAD_CYC = 1,
  parameter int ARRAY_LAT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_BW-1:0] num_vec,
  output logic              busy,
  output logic              done,
  output logic              we_rl,
  output logic              in_rd_en,
  output logic [CNT_BW-1:0] in_rd_addr,
  output logic              sa_din_valid,
  output logic              out_wr_en,
  output logic [CNT_BW-1:0] out_wr_addr,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] WLOAD_LAST = 4'(WLOAD_CYC - 1);

  logic [2:0]           state;
  logic [2:0]           state_n;
  logic [3:0]           wcnt;
  logic [CNT_BW-1:0]    n_lat;
  logic [CNT_BW-1:0]    last_idx;
  logic [ARRAY_LAT-1:0] dline;
  logic                 kill;

  assign last_idx  = n_lat - CNT_BW'(1);
  assign kill      = abort && (state != S_IDLE);
  assign out_wr_en = dline[ARRAY_LAT-1];
  assign dbg_state = state;

  // Outputs are registered from state_n, so each strobe lines up with the state it belongs to.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start && !abort) state_n = (num_vec == '0) ? S_DONE : S_LOAD_W;
      S_LOAD_W: if (wcnt == WLOAD_LAST) state_n = S_STREAM;
      S_STREAM: if (in_rd_addr == last_idx) state_n = S_DRAIN;
      S_DRAIN:  if (out_wr_en && (out_wr_addr == last_idx)) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      we_rl        <= 1'b0;
      in_rd_en     <= 1'b0;
      in_rd_addr   <= '0;
      sa_din_valid <= 1'b0;
      out_wr_addr  <= '0;
      wcnt         <= '0;
      n_lat        <= '0;
      dline        <= '0;
    end else begin
      state    <= state_n;
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
      we_rl    <= (state_n == S_LOAD_W);
      in_rd_en <= (state_n == S_STREAM);
      wcnt     <= (state == S_LOAD_W && state_n == S_LOAD_W) ? wcnt + 4'd1 : 4'd0;
      // The read address doubles as the stream beat counter.
      in_rd_addr <= (state == S_STREAM && state_n == S_STREAM) ? in_rd_addr + CNT_BW'(1) : '0;
      if (state == S_IDLE && state_n == S_LOAD_W) n_lat <= num_vec;
      else if (state_n == S_IDLE)                 n_lat <= '0;
      sa_din_valid <= kill ? 1'b0 : in_rd_en;
      if (kill) begin
        dline <= '0;
      end else begin
        dline[0] <= sa_din_valid;
        for (int i = 1; i < ARRAY_LAT; i++) dline[i] <= dline[i-1];
      end
      // Write address doubles as the result beat counter used for the DRAIN exit.
      if (state_n == S_STREAM || state_n == S_DRAIN)
        out_wr_addr <= out_wr_en ? out_wr_addr + CNT_BW'(1) : out_wr_addr;
      else
        out_wr_addr <= '0;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: two configurations, per-cycle timing model plus a write-address scoreboard.
module tb_systolic_seq_ctrl;

  localparam int W_A = 1, L_A = 16, BW_A = 8;
  localparam int W_B = 3, L_B = 5,  BW_B = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start_a, abort_a, busy_a, done_a, we_a, rd_a, sa_a, wr_a;
  logic [BW_A-1:0] nv_a, rd_addr_a, wr_addr_a;
  logic [2:0]      dbg_a;
  logic            start_b, abort_b, busy_b, done_b, we_b, rd_b, sa_b, wr_b;
  logic [BW_B-1:0] nv_b, rd_addr_b, wr_addr_b;
  logic [2:0]      dbg_b;

  systolic_seq_ctrl #(.CNT_BW(BW_A), .WLOAD_CYC(W_A), .ARRAY_LAT(L_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .num_vec(nv_a),
    .busy(busy_a), .done(done_a), .we_rl(we_a), .in_rd_en(rd_a), .in_rd_addr(rd_addr_a),
    .sa_din_valid(sa_a), .out_wr_en(wr_a), .out_wr_addr(wr_addr_a), .dbg_state(dbg_a));

  systolic_seq_ctrl #(.CNT_BW(BW_B), .WLOAD_CYC(W_B), .ARRAY_LAT(L_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .num_vec(nv_b),
    .busy(busy_b), .done(done_b), .we_rl(we_b), .in_rd_en(rd_b), .in_rd_addr(rd_addr_b),
    .sa_din_valid(sa_b), .out_wr_en(wr_b), .out_wr_addr(wr_addr_b), .dbg_state(dbg_b));

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       we;
    logic       rd;
    logic [7:0] rd_addr;
    logic       sa;
    logic       wr;
    logic [7:0] wr_addr;
  } outs_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Job timeline relative to the cycle start is seen (t=0): W weight cycles,
  // N reads, valid one cycle after each read, results L cycles after valid, done right after.
  function automatic outs_t model(int t, int n, int w, int l, bit dead);
    outs_t e;
    int d;
    e = '0;
    if (dead) return e;
    if (n == 0) begin
      e.busy = (t == 1);
      e.done = (t == 1);
      return e;
    end
    d = w + n + 2 + l;
    e.busy = (t >= 1) && (t <= d);
    e.done = (t == d);
    e.we   = (t >= 1) && (t <= w);
    e.rd   = (t >= w + 1) && (t <= w + n);
    if (e.rd) e.rd_addr = 8'(t - w - 1);
    e.sa   = (t >= w + 2) && (t <= w + n + 1);
    e.wr   = (t >= w + 2 + l) && (t <= w + n + 1 + l);
    if (e.wr) e.wr_addr = 8'(t - (w + 2 + l));
    return e;
  endfunction

  function automatic outs_t observe(bit sel);
    outs_t o;
    if (sel) begin
      o = '{busy_b, done_b, we_b, rd_b, {5'b0, rd_addr_b}, sa_b, wr_b, {5'b0, wr_addr_b}};
    end else begin
      o = '{busy_a, done_a, we_a, rd_a, rd_addr_a, sa_a, wr_a, wr_addr_a};
    end
    return o;
  endfunction

  task automatic compare(input string tag, input outs_t o, input outs_t e);
    check_eq({tag, ".busy"},    32'(o.busy),    32'(e.busy));
    check_eq({tag, ".done"},    32'(o.done),    32'(e.done));
    check_eq({tag, ".we_rl"},   32'(o.we),      32'(e.we));
    check_eq({tag, ".rd_en"},   32'(o.rd),      32'(e.rd));
    check_eq({tag, ".rd_addr"}, 32'(o.rd_addr), 32'(e.rd_addr));
    check_eq({tag, ".sa_dv"},   32'(o.sa),      32'(e.sa));
    check_eq({tag, ".wr_en"},   32'(o.wr),      32'(e.wr));
    check_eq({tag, ".wr_addr"}, 32'(o.wr_addr), 32'(e.wr_addr));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit sel, input bit st, input bit ab, input int nv);
    start_a = sel ? 1'b0 : st;
    abort_a = sel ? 1'b0 : ab;
    nv_a    = sel ? '0 : BW_A'(nv);
    start_b = sel ? st : 1'b0;
    abort_b = sel ? ab : 1'b0;
    nv_b    = sel ? BW_B'(nv) : '0;
  endtask

  // One job on the selected DUT: noise re-pulses start and changes num_vec while busy;
  // abort_at / rst_at (0 = none) cancel the job in that cycle.
  task automatic run_job(input bit sel, input int n, input bit noise, input int abort_at, input int rst_at);
    int    w, l, d, maxn;
    bit    dead;
    outs_t o;
    string tag;
    w    = sel ? W_B : W_A;
    l    = sel ? L_B : L_A;
    maxn = sel ? 7 : 255;
    d    = (n == 0) ? 1 : w + n + 2 + l;
    dead = 1'b0;
    tag  = $sformatf("%s_n%0d", sel ? "b" : "a", n);
    @(posedge clk); #1;
    drive(sel, 1'b1, 1'b0, n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'(i));
    @(negedge clk);
    compare({tag, "_t0"}, observe(sel), model(0, n, w, l, 1'b0));
    for (int t = 1; t <= d + 1; t++) begin
      @(posedge clk); #1;
      if (t == abort_at) drive(sel, 1'b0, 1'b1, 0);
      else if (noise && !dead && t <= d && (abort_at == 0 || t < abort_at))
        drive(sel, 1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 1) != 0) ? 9 % (maxn + 1) : int'($urandom_range(0, maxn)));
      else drive(sel, 1'b0, 1'b0, 0);
      if (t == rst_at) begin
        #1 rst = 1'b1;
        #1 compare({tag, "_rst_async"}, observe(sel), '0);
        dead = 1'b1;
        exp_q.delete();
        #1 rst = 1'b0;
      end
      if (abort_at != 0 && t > abort_at) dead = 1'b1;
      @(negedge clk);
      o = observe(sel);
      if (o.wr) check_eq({tag, "_sb_wr_addr"}, 32'(o.wr_addr), (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
      compare($sformatf("%s_t%0d", tag, t), o, model(t, n, w, l, dead));
      if (t == abort_at) exp_q.delete();
    end
    check_eq({tag, "_wr_count"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    compare("reset_a", observe(1'b0), '0);
    compare("reset_b", observe(1'b1), '0);
    @(posedge clk); #1 rst = 1'b0;

    run_job(1'b0, 4, 1'b0, 0, 0);                 // nominal default timing
    run_job(1'b0, 0, 1'b0, 0, 0);                 // empty job
    run_job(1'b0, 4, 1'b1, 0, 0);                 // start/num_vec noise while busy
    run_job(1'b0, 6, 1'b0, W_A + 2, 0);           // abort on second read beat
    run_job(1'b0, 2, 1'b0, 0, 0);
    run_job(1'b0, 3, 1'b0, 0, W_A + 3 + 2 + 5);   // reset pulse while draining
    run_job(1'b0, 5, 1'b0, 0, 0);

    // abort together with start in IDLE must reject the job
    @(posedge clk); #1 drive(1'b0, 1'b1, 1'b1, 5);
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    compare("abort_start_idle", observe(1'b0), '0);
    repeat (3) @(negedge clk);
    compare("abort_start_idle_later", observe(1'b0), '0);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
      run_job(1'b0, n, 1'($urandom_range(0, 1)), 0, 0);
    end
    run_job(1'b0, 255, 1'b0, 0, 0);               // largest count, no wrap

    run_job(1'b1, 7, 1'b0, 0, 0);                 // alternate configuration, full count
    run_job(1'b1, 3, 1'b1, 0, 0);
    run_job(1'b1, 0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
